sys_ctrl_rx_decoder: RTL and testbench
======================================

Name: sys_ctrl_rx_decoder

Overview:
Command decoder between the UART RX data synchronizer and the register file / ALU.
- Consumes validated RX bytes and decodes four command frames: RF write, RF read, ALU with operands, ALU without operands.
- Issues register-file write/read strobes, ALU enable with function code, and the ALU clock-gate enable.
- Holds off read and ALU issue while the response/TX path is busy.

Parameters:
DATA_WIDTH, 8, RX byte and register data width
ADDRESS_WIDTH, 4, register file address width
RF_WR_CMD, 8'hAA, register write command byte
RF_RD_CMD, 8'hBB, register read command byte
ALU_W_OP_CMD, 8'hCC, ALU command with operands
ALU_W_NOP_CMD, 8'hDD, ALU command without operands
OPA_ADDR, 0, register address that receives operand A
OPB_ADDR, 1, register address that receives operand B
TIMEOUT_CYCLES, 65535, inter-byte timeout in REF_CLK cycles (used only with the optional feature)

Ports:
REF_CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
RX_P_DATA  in  DATA_WIDTH  synchronized RX byte
RX_D_VLD  in  1  one-cycle pulse; RX_P_DATA valid
RSP_BUSY  in  1  response/TX path cannot accept a new read or ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
WrEn  out  1  register write strobe, one cycle
RdEn  out  1  register read strobe, one cycle
Address  out  ADDRESS_WIDTH  register address
WrData  out  DATA_WIDTH  register write data
ALU_EN  out  1  ALU start pulse, one cycle
ALU_FUN  out  4  ALU function code
CLK_EN  out  1  ALU clock-gate enable
CMD_ERR  out  1  one-cycle pulse: unknown command byte
OVR_ERR  out  1  one-cycle pulse: byte dropped while not accepting

Behaviour:
- Reset: all outputs 0; state IDLE; internal address/data latches 0. RST asserted mid-frame aborts the frame; no partial strobe is issued.
- All outputs are registered. A byte is accepted on the REF_CLK edge where RX_D_VLD=1.
- States and transitions:
  - IDLE:
    - AA -> WR_ADDR
    - BB -> RD_ADDR
    - CC -> ALU_A
    - DD -> ALU_F
    - any other byte -> CMD_ERR pulse next cycle, remain in IDLE.
  - WR_ADDR: latch byte[ADDRESS_WIDTH-1:0] (upper bits ignored) -> WR_DATA.
  - WR_DATA: latch data -> ISSUE_WR.
  - ISSUE_WR: WrEn=1 with Address/WrData for exactly one cycle (the cycle after the data byte) -> IDLE. Never stalls on RSP_BUSY.
  - RD_ADDR: latch address -> ISSUE_RD.
  - ISSUE_RD: wait while RSP_BUSY=1; on the first cycle with RSP_BUSY=0, RdEn=1 for one cycle -> IDLE.
  - ALU_A: byte written to OPA_ADDR (WrEn pulse next cycle) -> ALU_B.
  - ALU_B: byte written to OPB_ADDR (WrEn pulse next cycle) -> ALU_F.
  - ALU_F: latch byte[3:0] to ALU_FUN; upper bits ignored -> ISSUE_ALU.
  - ISSUE_ALU: CLK_EN=1 from entry; wait for RSP_BUSY=0, then ALU_EN=1 for one cycle -> WAIT_ALU.
  - WAIT_ALU: CLK_EN stays 1 until the cycle after ALU_OUT_VLD=1, then CLK_EN=0 -> IDLE. ALU_OUT_VLD coincident with ALU_EN is not possible (ALU latency >= 1).
- Unbounded inter-byte gaps are legal by default; the decoder waits indefinitely in any collecting state.
- RX_D_VLD in ISSUE_RD, ISSUE_ALU or WAIT_ALU: byte dropped, OVR_ERR pulse next cycle, state unchanged. ISSUE_WR is a single cycle, so a byte arriving there is also dropped with OVR_ERR.
- ALU_FUN holds its value until the next ALU_F capture. DD reuses the operands already stored in reg OPA_ADDR/OPB_ADDR.
- Address and WrData hold their last value when strobes are low.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined: a counter resets on every accepted byte and increments in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_F. On reaching TIMEOUT_CYCLES it returns to IDLE and pulses CMD_ERR. Operand writes already issued are not undone.
- Undefined: no counter, no timeout; collecting states wait indefinitely.

Test Plan:
1. Bytes AA,05,3C -> one WrEn cycle with Address=5, WrData=3C, the cycle after the third RX_D_VLD; no other strobes.
2. BB,05 with RSP_BUSY=1 for 10 cycles -> RdEn held off, then a single RdEn pulse with Address=5 on the first cycle RSP_BUSY=0.
3. CC,0A,05,01 -> WrEn (addr0, 0A), then WrEn (addr1, 05). ALU_FUN=1, ALU_EN one pulse, CLK_EN high until the cycle after ALU_OUT_VLD. Then DD,0B -> ALU_FUN=B, with no WrEn.
4. Byte 12 in IDLE -> CMD_ERR pulse, no strobes. Any byte during WAIT_ALU -> OVR_ERR pulse, CLK_EN still high.
5. AA,07 then RST for 1 cycle, then 3C -> no WrEn; all outputs 0; 3C decoded as an unknown command (CMD_ERR).
6. FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=100: AA, then idle 100 cycles -> CMD_ERR, return to IDLE. Then BB,02 -> RdEn with Address=2.

Source files
------------

// File: rtl/sys_ctrl_rx_decoder.sv
// sys_ctrl_rx_decoder
// -------------------
// Command decoder between the UART RX synchronizer and the register file /
// ALU. Collects command frames from validated RX bytes and issues register
// write/read strobes, ALU start pulses and the ALU clock-gate enable.
//
// Frames:
//   RF_WR_CMD     addr data      -> WrEn pulse (Address, WrData)
//   RF_RD_CMD     addr           -> RdEn pulse once RSP_BUSY is low
//   ALU_W_OP_CMD  opA opB fun    -> WrEn to OPA_ADDR, WrEn to OPB_ADDR, ALU run
//   ALU_W_NOP_CMD fun            -> ALU run on the operands already stored
//
// Ports:
//   REF_CLK, RST      clock, synchronous active-high reset
//   RX_P_DATA         synchronized RX byte
//   RX_D_VLD          one-cycle pulse, RX_P_DATA valid
//   RSP_BUSY          response/TX path cannot take a read or ALU result
//   ALU_OUT_VLD       ALU result valid pulse
//   WrEn, RdEn        register write / read strobes (one cycle)
//   Address, WrData   register address / write data (held between strobes)
//   ALU_EN, ALU_FUN   ALU start pulse and function code
//   CLK_EN            ALU clock-gate enable
//   CMD_ERR           pulse: unknown command byte (or frame timeout)
//   OVR_ERR           pulse: byte dropped while not accepting
//   dbg_state_o       current FSM state, for checkers
//
// Handshake: RX_D_VLD is a valid-only interface with no ready back-pressure.
// A byte is consumed on every REF_CLK edge where RX_D_VLD=1; if the decoder
// is in an issue/wait state the byte is discarded and OVR_ERR reports it.
//
// Optional build macro: FRAME_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYCLES in the collecting states (abort to IDLE with CMD_ERR).
// Without it, collecting states wait indefinitely.

module sys_ctrl_rx_decoder #(
  parameter int unsigned                DATA_WIDTH     = 8,
  parameter int unsigned                ADDRESS_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0]      RF_WR_CMD      = 8'hAA,
  parameter logic [DATA_WIDTH-1:0]      RF_RD_CMD      = 8'hBB,
  parameter logic [DATA_WIDTH-1:0]      ALU_W_OP_CMD   = 8'hCC,
  parameter logic [DATA_WIDTH-1:0]      ALU_W_NOP_CMD  = 8'hDD,
  parameter logic [ADDRESS_WIDTH-1:0]   OPA_ADDR       = 0,
  parameter logic [ADDRESS_WIDTH-1:0]   OPB_ADDR       = 1,
  parameter int unsigned                TIMEOUT_CYCLES = 65535
) (
  input  logic                     REF_CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     RSP_BUSY,
  input  logic                     ALU_OUT_VLD,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_EN,
  output logic                     CMD_ERR,
  output logic                     OVR_ERR,
  output logic [3:0]               dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_ADDR   = 4'd1,
    WR_DATA   = 4'd2,
    ISSUE_WR  = 4'd3,
    RD_ADDR   = 4'd4,
    ISSUE_RD  = 4'd5,
    ALU_A     = 4'd6,
    ALU_B     = 4'd7,
    ALU_F     = 4'd8,
    ISSUE_ALU = 4'd9,
    WAIT_ALU  = 4'd10
  } state_e;

  state_e                   state_q;
  logic                     wr_en_q;
  logic                     rd_en_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic                     alu_en_q;
  logic [3:0]               alu_fun_q;
  logic                     clk_en_q;
  logic                     cmd_err_q;
  logic                     ovr_err_q;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  logic          collecting;

  // States where the decoder is waiting for the next byte of a frame.
  assign collecting = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                      (state_q == RD_ADDR) || (state_q == ALU_A)   ||
                      (state_q == ALU_B)   || (state_q == ALU_F);
`endif

  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      clk_en_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      tmr_q     <= '0;
`endif
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      ovr_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == RF_WR_CMD)          state_q <= WR_ADDR;
            else if (RX_P_DATA == RF_RD_CMD)     state_q <= RD_ADDR;
            else if (RX_P_DATA == ALU_W_OP_CMD)  state_q <= ALU_A;
            else if (RX_P_DATA == ALU_W_NOP_CMD) state_q <= ALU_F;
            else                                 cmd_err_q <= 1'b1;
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_q  <= RX_P_DATA[ADDRESS_WIDTH-1:0];
            state_q <= WR_DATA;
          end
        end
        WR_DATA: begin
          // Strobe is raised here so it is visible in the ISSUE_WR cycle.
          if (RX_D_VLD) begin
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= ISSUE_WR;
          end
        end
        ISSUE_WR: begin
          ovr_err_q <= RX_D_VLD;
          state_q   <= IDLE;
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            addr_q  <= RX_P_DATA[ADDRESS_WIDTH-1:0];
            state_q <= ISSUE_RD;
          end
        end
        ISSUE_RD: begin
          ovr_err_q <= RX_D_VLD;
          if (!RSP_BUSY) begin
            rd_en_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        ALU_A: begin
          if (RX_D_VLD) begin
            addr_q    <= OPA_ADDR;
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= ALU_B;
          end
        end
        ALU_B: begin
          if (RX_D_VLD) begin
            addr_q    <= OPB_ADDR;
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= ALU_F;
          end
        end
        ALU_F: begin
          // Clock gate opens on entry to ISSUE_ALU so the ALU is running
          // before ALU_EN arrives.
          if (RX_D_VLD) begin
            alu_fun_q <= RX_P_DATA[3:0];
            clk_en_q  <= 1'b1;
            state_q   <= ISSUE_ALU;
          end
        end
        ISSUE_ALU: begin
          ovr_err_q <= RX_D_VLD;
          if (!RSP_BUSY) begin
            alu_en_q <= 1'b1;
            state_q  <= WAIT_ALU;
          end
        end
        WAIT_ALU: begin
          ovr_err_q <= RX_D_VLD;
          if (ALU_OUT_VLD) begin
            clk_en_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef FRAME_TIMEOUT_EN
      // Timer counts idle cycles inside a frame; any accepted byte or a
      // non-collecting state clears it. Expiry overrides the case above.
      if (collecting && !RX_D_VLD) begin
        if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmr_q     <= '0;
          state_q   <= IDLE;
          cmd_err_q <= 1'b1;
        end else begin
          tmr_q <= tmr_q + 1'b1;
        end
      end else begin
        tmr_q <= '0;
      end
`endif
    end
  end

  assign WrEn        = wr_en_q;
  assign RdEn        = rd_en_q;
  assign Address     = addr_q;
  assign WrData      = wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_EN      = clk_en_q;
  assign CMD_ERR     = cmd_err_q;
  assign OVR_ERR     = ovr_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// Directed testbench for sys_ctrl_rx_decoder. Inputs change on the falling
// edge, outputs are sampled on the falling edge (or just after it).

module tb_sys_ctrl_rx_decoder;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_vld = 1'b0;
  logic       rsp_busy = 1'b0;
  logic       alu_out_vld = 1'b0;

  logic       wr_en, rd_en, alu_en, clk_en, cmd_err, ovr_err;
  logic [3:0] address;
  logic [7:0] wr_data;
  logic [3:0] alu_fun;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  sys_ctrl_rx_decoder #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .REF_CLK     (clk),
    .RST         (rst),
    .RX_P_DATA   (rx_data),
    .RX_D_VLD    (rx_vld),
    .RSP_BUSY    (rsp_busy),
    .ALU_OUT_VLD (alu_out_vld),
    .WrEn        (wr_en),
    .RdEn        (rd_en),
    .Address     (address),
    .WrData      (wr_data),
    .ALU_EN      (alu_en),
    .ALU_FUN     (alu_fun),
    .CLK_EN      (clk_en),
    .CMD_ERR     (cmd_err),
    .OVR_ERR     (ovr_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- strobe counters (monitor) ----------------
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, cmd_cnt = 0, ovr_cnt = 0;

  always @(negedge clk) begin
    wr_cnt  <= wr_cnt  + int'(wr_en);
    rd_cnt  <= rd_cnt  + int'(rd_en);
    alu_cnt <= alu_cnt + int'(alu_en);
    cmd_cnt <= cmd_cnt + int'(cmd_err);
    ovr_cnt <= ovr_cnt + int'(ovr_err);
  end

  int s_wr, s_rd, s_alu, s_cmd, s_ovr;

  // ---------------- scoreboard / checker ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a falling edge; the byte is taken on the next rising edge and
  // the task returns on the following falling edge, where registered
  // results of that byte are visible.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic snap();
    #1;
    s_wr = wr_cnt; s_rd = rd_cnt; s_alu = alu_cnt; s_cmd = cmd_cnt; s_ovr = ovr_cnt;
  endtask

  // Compare counter deltas since the last snap() against expected counts.
  task automatic check_deltas(input string tag, input int ewr, input int erd,
                              input int ealu, input int ecmd, input int eovr);
    #1;
    check({tag, "_wr"},  32'(wr_cnt  - s_wr),  32'(ewr));
    check({tag, "_rd"},  32'(rd_cnt  - s_rd),  32'(erd));
    check({tag, "_alu"}, 32'(alu_cnt - s_alu), 32'(ealu));
    check({tag, "_cmd"}, 32'(cmd_cnt - s_cmd), 32'(ecmd));
    check({tag, "_ovr"}, 32'(ovr_cnt - s_ovr), 32'(eovr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"},  32'(wr_en),   32'd0);
    check({tag, "_rden"},  32'(rd_en),   32'd0);
    check({tag, "_addr"},  32'(address), 32'd0);
    check({tag, "_wdata"}, 32'(wr_data), 32'd0);
    check({tag, "_aluen"}, 32'(alu_en),  32'd0);
    check({tag, "_alufn"}, 32'(alu_fun), 32'd0);
    check({tag, "_clken"}, 32'(clk_en),  32'd0);
    check({tag, "_cmd"},   32'(cmd_err), 32'd0);
    check({tag, "_ovr"},   32'(ovr_err), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // T1: register write AA,05,3C
    snap();
    send_byte(8'hAA);
    send_byte(8'h05);
    check("t1_wren_early", 32'(wr_en), 32'd0);
    send_byte(8'h3C);
    check("t1_wren",  32'(wr_en),   32'd1);
    check("t1_addr",  32'(address), 32'h5);
    check("t1_wdata", 32'(wr_data), 32'h3C);
    @(negedge clk);
    check("t1_wren_off", 32'(wr_en), 32'd0);
    check("t1_addr_hold", 32'(address), 32'h5);
    @(negedge clk);
    check_deltas("t1", 1, 0, 0, 0, 0);

    // T2: register read BB,05 held off by RSP_BUSY for 10 cycles
    @(negedge clk);
    snap();
    rsp_busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h05);
    repeat (10) @(negedge clk);
    #1;
    check("t2_rd_held", 32'(rd_cnt - s_rd), 32'd0);
    rsp_busy = 1'b0;
    @(negedge clk);
    check("t2_rden", 32'(rd_en),   32'd1);
    check("t2_addr", 32'(address), 32'h5);
    @(negedge clk);
    check("t2_rden_off", 32'(rd_en), 32'd0);
    check_deltas("t2", 0, 1, 0, 0, 0);

    // T3: ALU with operands CC,0A,05,01
    @(negedge clk);
    snap();
    send_byte(8'hCC);
    send_byte(8'h0A);
    check("t3_opa_wren", 32'(wr_en),   32'd1);
    check("t3_opa_addr", 32'(address), 32'h0);
    check("t3_opa_data", 32'(wr_data), 32'h0A);
    send_byte(8'h05);
    check("t3_opb_wren", 32'(wr_en),   32'd1);
    check("t3_opb_addr", 32'(address), 32'h1);
    check("t3_opb_data", 32'(wr_data), 32'h05);
    send_byte(8'h01);
    check("t3_alufun", 32'(alu_fun), 32'h1);
    check("t3_clken_entry", 32'(clk_en), 32'd1);
    check("t3_aluen_early", 32'(alu_en), 32'd0);
    @(negedge clk);
    check("t3_aluen", 32'(alu_en), 32'd1);
    @(negedge clk);
    check("t3_aluen_off", 32'(alu_en), 32'd0);
    // T4b: byte during WAIT_ALU is dropped
    send_byte(8'h77);
    check("t4_ovr", 32'(ovr_err), 32'd1);
    check("t4_clken_kept", 32'(clk_en), 32'd1);
    @(negedge clk);
    check("t4_ovr_off", 32'(ovr_err), 32'd0);
    alu_out_vld = 1'b1;
    check("t3_clken_at_vld", 32'(clk_en), 32'd1);
    @(negedge clk);
    alu_out_vld = 1'b0;
    check("t3_clken_off", 32'(clk_en), 32'd0);
    check_deltas("t3", 2, 0, 1, 0, 1);

    // T3b: ALU without operands DD,0B
    @(negedge clk);
    snap();
    send_byte(8'hDD);
    send_byte(8'h0B);
    check("t3b_alufun", 32'(alu_fun), 32'hB);
    check("t3b_clken",  32'(clk_en),  32'd1);
    @(negedge clk);
    check("t3b_aluen", 32'(alu_en), 32'd1);
    repeat (3) @(negedge clk);
    check("t3b_clken_wait", 32'(clk_en), 32'd1);
    alu_out_vld = 1'b1;
    @(negedge clk);
    alu_out_vld = 1'b0;
    check("t3b_clken_off", 32'(clk_en), 32'd0);
    check("t3b_alufun_hold", 32'(alu_fun), 32'hB);
    check_deltas("t3b", 0, 0, 1, 0, 0);

    // T4: unknown command in IDLE
    @(negedge clk);
    snap();
    send_byte(8'h12);
    check("t4_cmd", 32'(cmd_err), 32'd1);
    @(negedge clk);
    check("t4_cmd_off", 32'(cmd_err), 32'd0);
    check_deltas("t4", 0, 0, 0, 1, 0);

    // T5: reset mid-frame aborts; next byte is a fresh command
    @(negedge clk);
    snap();
    send_byte(8'hAA);
    send_byte(8'h07);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("t5_rst");
    send_byte(8'h3C);
    check("t5_cmd", 32'(cmd_err), 32'd1);
    check("t5_wren", 32'(wr_en), 32'd0);
    @(negedge clk);
    check_deltas("t5", 0, 0, 0, 1, 0);

`ifdef FRAME_TIMEOUT_EN
    // T6: inter-byte timeout of 100 cycles
    @(negedge clk);
    snap();
    send_byte(8'hAA);
    repeat (99) @(negedge clk);
    check("t6_cmd_before", 32'(cmd_err), 32'd0);
    @(negedge clk);
    check("t6_cmd_timeout", 32'(cmd_err), 32'd1);
    @(negedge clk);
    send_byte(8'hBB);
    send_byte(8'h02);
    @(negedge clk);
    check("t6_rden", 32'(rd_en),   32'd1);
    check("t6_addr", 32'(address), 32'h2);
    @(negedge clk);
    check_deltas("t6", 0, 1, 0, 1, 0);
`else
    // T6: without the timeout a long gap inside a frame is harmless
    @(negedge clk);
    snap();
    send_byte(8'hAA);
    repeat (200) @(negedge clk);
    check("t6_cmd_none", 32'(cmd_err), 32'd0);
    send_byte(8'h09);
    send_byte(8'h5A);
    check("t6_wren",  32'(wr_en),   32'd1);
    check("t6_addr",  32'(address), 32'h9);
    check("t6_wdata", 32'(wr_data), 32'h5A);
    @(negedge clk);
    check_deltas("t6", 1, 0, 0, 0, 0);
`endif

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
